// File: rtl/ahb_spi_pkg.sv
// Shared register map, bit positions and FSM encoding for the AHB SPI master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahb_spi_pkg;

  // Register word offsets (HADDR[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_CS      = 2;
  localparam int CTRL_DIV_LSB = 8;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  // A byte is 16 half-periods of sclk; index of the final one
  localparam logic [3:0] LAST_HALF = 4'd15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI byte shifter: MSB first, half-period of (div+1) clocks, div latched at start.
// Latency: busy the cycle after start, done pulses in the last of 16*(div+1) busy cycles.
// Backpressure: start is ignored while busy; abort drops the transfer without done.
module spi_shift_engine
  import ahb_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] div,
  input  logic [7:0] tx_byte,
  input  logic       spi_miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       spi_sclk,
  output logic       spi_mosi
);

  spi_state_t state_q, state_d;
  logic [7:0] div_lat;
  logic [7:0] div_cnt;
  logic [3:0] hp_cnt;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       hp_end;
  logic       last_end;

  assign hp_end   = (div_cnt == div_lat);
  assign last_end = hp_end && (hp_cnt == LAST_HALF);
  assign rx_byte  = rx_sh;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start from idle, leave on abort or after the 16th half-period
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (abort || last_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: abort suppresses the completion pulse
  always_comb begin
    busy = (state_q == ST_SHIFT);
    done = busy && !abort && last_end;
  end

  // Timing and shift datapath: rising sclk samples miso, falling sclk advances mosi
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_lat  <= '0;
      div_cnt  <= '0;
      hp_cnt   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      div_lat  <= div;
      div_cnt  <= '0;
      hp_cnt   <= '0;
      tx_sh    <= tx_byte;
      rx_sh    <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= tx_byte[7];
    end else if (state_q == ST_SHIFT) begin
      if (abort) begin
        spi_sclk <= 1'b0;
        div_cnt  <= '0;
      end else if (hp_end) begin
        div_cnt  <= '0;
        hp_cnt   <= hp_cnt + 4'd1;
        spi_sclk <= ~spi_sclk;
        if (!spi_sclk) begin
          rx_sh <= {rx_sh[6:0], spi_miso};
        end else begin
          tx_sh    <= {tx_sh[6:0], 1'b0};
          spi_mosi <= tx_sh[6];
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ahb_spi_master.sv
// AHB-Lite slave exposing DATA/CTRL/STATUS registers in front of a mode-0 SPI byte engine.
// Latency: zero wait states; register writes act in the data phase, reads return in the data phase.
// Backpressure: none on the bus (HREADYOUT=1); DATA writes while busy are dropped and flag OVR.
module ahb_spi_master
  import ahb_spi_pkg::*;
#(
  parameter logic [7:0] RST_DIV = 8'd3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  input  logic        spi_miso,
  output logic        spi_irq
);

  logic       ap_vld, ap_write;
  logic [1:0] ap_addr;
  logic       ctrl_en, ctrl_ie, ctrl_cs;
  logic [7:0] ctrl_div;
  logic       done_q, ovr_q;
  logic [7:0] rx_q;
  logic       eng_busy, eng_done, eng_start, eng_abort;
  logic [7:0] eng_rx;
  logic       data_wr, ctrl_wr, stat_wr, rd_en, en_next;
  logic       unused_bits;

  // Size, sub-word address bits, sequential/non-seq and upper write data carry no meaning here
  assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

  assign data_wr   = ap_vld && ap_write && (ap_addr == REG_DATA);
  assign ctrl_wr   = ap_vld && ap_write && (ap_addr == REG_CTRL);
  assign stat_wr   = ap_vld && ap_write && (ap_addr == REG_STATUS);
  assign rd_en     = ap_vld && !ap_write;
  // Abort follows the EN value being written so the engine stops as EN reads back 0
  assign en_next   = ctrl_wr ? HWDATA[CTRL_EN] : ctrl_en;
  assign eng_start = data_wr && ctrl_en && !eng_busy;
  assign eng_abort = !en_next;

  assign HREADYOUT = 1'b1;
  assign spi_cs_n  = ~ctrl_cs;
  assign spi_irq   = done_q & ctrl_ie;

  // Address phase capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_vld   <= 1'b0;
      ap_write <= 1'b0;
      ap_addr  <= REG_DATA;
    end else if (HREADY) begin
      ap_vld   <= HSEL && HTRANS[1];
      ap_write <= HWRITE;
      ap_addr  <= HADDR[3:2];
    end
  end

  // CTRL register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_en  <= 1'b0;
      ctrl_ie  <= 1'b0;
      ctrl_cs  <= 1'b0;
      ctrl_div <= RST_DIV;
    end else if (ctrl_wr) begin
      ctrl_en  <= HWDATA[CTRL_EN];
      ctrl_ie  <= HWDATA[CTRL_IE];
      ctrl_cs  <= HWDATA[CTRL_CS];
      ctrl_div <= HWDATA[CTRL_DIV_LSB +: 8];
    end
  end

  // STATUS flags and RX holding register; hardware DONE set beats software clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      rx_q   <= '0;
    end else begin
      if (eng_done)                        done_q <= 1'b1;
      else if (stat_wr && HWDATA[STAT_DONE]) done_q <= 1'b0;
      if (data_wr && ctrl_en && eng_busy)  ovr_q <= 1'b1;
      else if (stat_wr && HWDATA[STAT_OVR])  ovr_q <= 1'b0;
      if (eng_done) rx_q <= eng_rx;
    end
  end

  // Read data mux for the data phase
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (ap_addr)
        REG_DATA:   HRDATA[7:0] = rx_q;
        REG_CTRL: begin
          HRDATA[CTRL_EN]            = ctrl_en;
          HRDATA[CTRL_IE]            = ctrl_ie;
          HRDATA[CTRL_CS]            = ctrl_cs;
          HRDATA[CTRL_DIV_LSB +: 8]  = ctrl_div;
        end
        REG_STATUS: begin
          HRDATA[STAT_BUSY] = eng_busy;
          HRDATA[STAT_DONE] = done_q;
          HRDATA[STAT_OVR]  = ovr_q;
        end
        default:    HRDATA = '0;
      endcase
    end
  end

  spi_shift_engine u_engine (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .start    (eng_start),
    .abort    (eng_abort),
    .div      (ctrl_div),
    .tx_byte  (HWDATA[7:0]),
    .spi_miso (spi_miso),
    .busy     (eng_busy),
    .done     (eng_done),
    .rx_byte  (eng_rx),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi)
  );

endmodule

// File: tb/tb_ahb_spi_master.sv
// Directed and randomized bench for ahb_spi_master with a byte-level SPI reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ahb_spi_master;

  localparam logic [1:0] R_DATA = 2'd0, R_CTRL = 2'd1, R_STATUS = 2'd2;

  logic        HCLK, HRESETn, HSEL, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADYOUT, spi_sclk, spi_mosi, spi_cs_n, spi_miso, spi_irq;

  int checks = 0;
  int failures = 0;

  // Monitor state: free-running counters, bench records bases per transfer
  int         rise_total = 0;
  int         hi_total = 0;
  logic [7:0] mosi_hist = '0;
  int         rise_base = 0;
  int         hi_base = 0;
  int         miso_mode = 0;   // 0 loopback, 1 tied high, 2 pattern
  logic [7:0] miso_pat = '0;
  int         miso_idx;

  ahb_spi_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .spi_irq(spi_irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Slave side of the wire: record mosi at each rising sclk
  always @(posedge spi_sclk) begin
    rise_total <= rise_total + 1;
    mosi_hist  <= {mosi_hist[6:0], spi_mosi};
  end

  always @(posedge HCLK) if (spi_sclk === 1'b1) hi_total <= hi_total + 1;

  always_comb begin
    miso_idx = rise_total - rise_base;
    spi_miso = 1'b0;
    case (miso_mode)
      0: spi_miso = spi_mosi;
      1: spi_miso = 1'b1;
      default: if (miso_idx >= 0 && miso_idx < 8) spi_miso = miso_pat[3'(7 - miso_idx)];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] ctrl_word(input logic en, input logic ie, input logic cs,
                                            input logic [7:0] div);
    return {16'h0, div, 5'b0, cs, ie, en};
  endfunction

  task automatic ahb_addr(input logic [1:0] r, input logic wr);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {28'h0, r, 2'b00}; HWRITE = wr;
  endtask

  task automatic ahb_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  // Returns at the falling edge inside the data phase; the write lands on the next rising edge
  task automatic ahb_write(input logic [1:0] r, input logic [31:0] d);
    @(negedge HCLK); ahb_addr(r, 1'b1);
    @(negedge HCLK); ahb_idle(); HWDATA = d;
  endtask

  task automatic ahb_read(input logic [1:0] r, output logic [31:0] d);
    @(negedge HCLK); ahb_addr(r, 1'b0);
    @(negedge HCLK); d = HRDATA; ahb_idle();
  endtask

  // Back-to-back STATUS reads, counting cycles with BUSY set; starts inside a write data phase
  task automatic run_poll(output int busy_cyc, output logic [31:0] fin_stat);
    busy_cyc = 0;
    fin_stat = '0;
    ahb_addr(R_STATUS, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge HCLK);
      fin_stat = HRDATA;
      if (!HRDATA[0]) break;
      busy_cyc++;
    end
    ahb_idle();
  endtask

  task automatic xfer(input logic [7:0] tx, output int bc, output logic [31:0] st);
    rise_base = rise_total;
    hi_base   = hi_total;
    ahb_write(R_DATA, {24'h0, tx});
    run_poll(bc, st);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sclk"}, {31'h0, spi_sclk}, 32'h0);
    chk({tag, "_mosi"}, {31'h0, spi_mosi}, 32'h0);
    chk({tag, "_cs_n"}, {31'h0, spi_cs_n}, 32'h1);
    chk({tag, "_irq"},  {31'h0, spi_irq},  32'h0);
    chk({tag, "_hrdata"}, HRDATA, 32'h0);
    chk({tag, "_hreadyout"}, {31'h0, HREADYOUT}, 32'h1);
  endtask

  initial begin
    int          bc;
    logic [31:0] st, rd;
    logic [7:0]  tx, div, exp_rx;

    HRESETn = 1'b0; HREADY = 1'b1; HSIZE = 3'b010; HWDATA = '0; HADDR = '0;
    ahb_idle();
    repeat (3) @(negedge HCLK);
    check_reset_outputs("por");
    HRESETn = 1'b1;

    ahb_read(R_CTRL, rd);   chk("ctrl_reset", rd, 32'h0000_0300);
    ahb_read(R_STATUS, rd); chk("status_reset", rd, 32'h0);
    ahb_read(R_DATA, rd);   chk("data_reset", rd, 32'h0);

    // DATA write with EN=0 is dropped silently
    ahb_write(R_DATA, 32'h55);
    ahb_read(R_STATUS, rd); chk("en0_drop_status", rd, 32'h0);

    // Loopback A5 at DIV=1
    ahb_write(R_CTRL, ctrl_word(1'b1, 1'b0, 1'b1, 8'd1));
    @(negedge HCLK); chk("cs_n_follows_ctrl", {31'h0, spi_cs_n}, 32'h0);
    miso_mode = 0;
    xfer(8'hA5, bc, st);
    chk("a5_busy_cycles", bc, 32);
    chk("a5_status", st[2:0], 3'b010);
    chk("a5_mosi_seq", mosi_hist, 8'hA5);
    chk("a5_sclk_high", hi_total - hi_base, 16);
    chk("a5_sclk_idle", {31'h0, spi_sclk}, 32'h0);
    ahb_read(R_DATA, rd); chk("a5_rx", rd, 32'hA5);

    // DIV=0, miso tied high
    ahb_write(R_CTRL, ctrl_word(1'b1, 1'b0, 1'b1, 8'd0));
    miso_mode = 1;
    xfer(8'h3C, bc, st);
    chk("div0_busy_cycles", bc, 16);
    chk("div0_sclk_high", hi_total - hi_base, 8);
    chk("div0_mosi_seq", mosi_hist, 8'h3C);
    ahb_read(R_DATA, rd); chk("div0_rx", rd, 32'hFF);

    // Randomized bytes, dividers and miso sources
    for (int k = 0; k < 6; k++) begin
      div       = 8'($urandom_range(0, 3));
      tx        = 8'($urandom);
      miso_pat  = 8'($urandom);
      miso_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      exp_rx    = (miso_mode == 2) ? miso_pat : tx;
      ahb_write(R_CTRL, ctrl_word(1'b1, 1'b0, 1'b1, div));
      xfer(tx, bc, st);
      chk("rnd_busy_cycles", bc, 16 * (int'(div) + 1));
      chk("rnd_status", st[2:0], 3'b010);
      chk("rnd_mosi_seq", mosi_hist, tx);
      chk("rnd_sclk_high", hi_total - hi_base, 8 * (int'(div) + 1));
      ahb_read(R_DATA, rd); chk("rnd_rx", rd, {24'h0, exp_rx});
    end

    // Interrupt and its W1C clear
    miso_mode = 0;
    ahb_write(R_CTRL, ctrl_word(1'b1, 1'b1, 1'b1, 8'd2));
    ahb_write(R_STATUS, 32'h6);
    @(negedge HCLK); chk("irq_cleared_before", {31'h0, spi_irq}, 32'h0);
    xfer(8'h81, bc, st);
    chk("irq_busy_cycles", bc, 48);
    chk("irq_set", {31'h0, spi_irq}, 32'h1);
    ahb_write(R_STATUS, 32'h2);
    chk("irq_held_in_data_phase", {31'h0, spi_irq}, 32'h1);
    @(negedge HCLK); chk("irq_w1c", {31'h0, spi_irq}, 32'h0);

    // Overrun: second DATA write mid-transfer
    ahb_write(R_CTRL, ctrl_word(1'b1, 1'b0, 1'b1, 8'd1));
    rise_base = rise_total;
    ahb_write(R_DATA, 32'h96);
    repeat (6) @(negedge HCLK);
    ahb_write(R_DATA, 32'h0F);
    run_poll(bc, st);
    chk("ovr_status", st[2:0], 3'b110);
    chk("ovr_mosi_seq", mosi_hist, 8'h96);
    ahb_read(R_DATA, rd); chk("ovr_rx_first", rd, 32'h96);
    ahb_write(R_STATUS, 32'h4);
    ahb_read(R_STATUS, rd); chk("ovr_w1c", rd, 32'h2);

    // Abort by clearing EN during half-period 5 (DIV=3)
    ahb_write(R_CTRL, ctrl_word(1'b1, 1'b0, 1'b1, 8'd3));
    ahb_write(R_STATUS, 32'h6);
    ahb_write(R_DATA, 32'hC3);
    repeat (16) @(negedge HCLK);
    ahb_write(R_CTRL, ctrl_word(1'b0, 1'b0, 1'b1, 8'd3));
    ahb_addr(R_STATUS, 1'b0);
    @(negedge HCLK);
    chk("abort_status", HRDATA[2:0], 3'b000);
    chk("abort_sclk", {31'h0, spi_sclk}, 32'h0);
    ahb_idle();
    repeat (80) @(negedge HCLK);
    ahb_read(R_STATUS, rd); chk("abort_no_done", rd, 32'h0);
    ahb_read(R_DATA, rd);   chk("abort_rx_kept", rd, 32'h96);

    // Reset during half-period 9 (DIV=1)
    ahb_write(R_CTRL, ctrl_word(1'b1, 1'b1, 1'b1, 8'd1));
    ahb_write(R_DATA, 32'h5A);
    repeat (17) @(negedge HCLK);
    chk("pre_reset_cs_n", {31'h0, spi_cs_n}, 32'h0);
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (40) @(negedge HCLK);
    ahb_read(R_STATUS, rd); chk("midrst_no_done", rd, 32'h0);
    ahb_read(R_CTRL, rd);   chk("midrst_ctrl", rd, 32'h0000_0300);
    ahb_read(R_DATA, rd);   chk("midrst_rx", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_spi_master.md
AHB_SPI_MASTER -- requirements
Module: ahb_spi_master

Interface
REQ-001 SHALL have parameter RST_DIV, default 8'd3, reset value of CTRL.DIV.
REQ-002 SHALL have one clock and an asynchronous active-low reset, ports HCLK and HRESETn; polarity and synchronicity are fixed.
REQ-003 HCLK  in  1  system clock; all state on rising edge.
REQ-004 HRESETn  in  1  asynchronous active-low reset.
REQ-005 HSEL  in  1  slave select from address decoder.
REQ-006 HREADY  in  1  bus ready (muxed).
REQ-007 HADDR  in  32  address; bits [3:2] decoded.
REQ-008 HTRANS  in  2  transfer type; HTRANS[1]=1 means active.
REQ-009 HWRITE  in  1  write when 1.
REQ-010 HSIZE  in  3  transfer size; accepted, not decoded.
REQ-011 HWDATA  in  32  write data, data phase.
REQ-012 HRDATA  out  32  read data, data phase.
REQ-013 HREADYOUT  out  1  tied 1, zero wait states.
REQ-014 spi_sclk, spi_mosi, spi_cs_n  out  1 each  SPI mode-0 master pins.
REQ-015 spi_miso  in  1  SPI serial input.
REQ-016 spi_irq  out  1  level interrupt to IRQ[15:0] slot.

Function
REQ-017 Address phase SHALL be registered (addr[3:2], write, valid) when HSEL & HREADY & HTRANS[1]; write/read acts in the following cycle.
REQ-018 Registers: 0x0 DATA (W: TX byte [7:0], R: last RX byte), 0x4 CTRL (bit0 EN, bit1 IE, bit2 CS, [15:8] DIV), 0x8 STATUS (bit0 BUSY RO, bit1 DONE W1C, bit2 OVR W1C), 0xC reads 0, writes ignored.
REQ-019 spi_cs_n SHALL equal ~CTRL.CS; hardware never drives CS itself.
REQ-020 FSM states IDLE, SHIFT; IDLE->SHIFT on DATA write with EN=1 and BUSY=0; SHIFT->IDLE after 16th half-period or when EN cleared.
REQ-021 On start (cycle T+1 after write data phase) BUSY=1, DIV latched, spi_mosi = TX[7], spi_sclk=0.
REQ-022 Half-period SHALL be DIV+1 HCLK cycles; sclk toggles at each half-period end; MSB first.
REQ-023 Rising sclk edge SHALL sample spi_miso into shift LSB; falling edge SHALL shift and present next TX bit on spi_mosi.
REQ-024 Completion at T+1+16*(DIV+1): BUSY=0, DONE=1, DATA-read = 8 received bits, sclk=0.
REQ-025 DATA write while BUSY=1 SHALL be dropped and set OVR; DATA write with EN=0 SHALL be dropped without OVR.
REQ-026 CTRL.DIV write during SHIFT SHALL not affect the running transfer.
REQ-027 EN cleared during SHIFT SHALL abort: IDLE next cycle, sclk=0, DONE not set, RX unchanged.
REQ-028 Hardware DONE set and W1C in same cycle: set wins.
REQ-029 spi_irq SHALL equal DONE & IE, combinational from registers.
REQ-030 DIV=0 SHALL be legal: sclk = HCLK/2.

Reset
REQ-031 On HRESETn low: FSM IDLE, CTRL = {RST_DIV, CS=0, IE=0, EN=0}, DONE=OVR=0, RX=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, spi_irq=0, HRDATA=0.
REQ-032 Reset mid-transfer SHALL abandon it with no DONE after release.

Structure
REQ-033 Package ahb_spi_pkg SHALL hold register offsets, bit positions, state encoding.
REQ-034 Shift/timing engine SHALL be sub-module spi_shift_engine (start, div, abort in; busy, done pulse, rx byte, pins out); AHB register logic stays in top.

Verification
REQ-035 EN=1, DIV=1, write DATA=0xA5, miso loopback from mosi -> 32 cycles busy, mosi sequence 1,0,1,0,0,1,0,1, RX=0xA5, DONE=1.
REQ-036 DIV=0, miso tied 1, write 0x3C -> 16 busy cycles, RX=0xFF, sclk period 2 HCLK.
REQ-037 IE=1, transfer completes -> spi_irq=1; write STATUS=0x2 -> spi_irq=0 next cycle.
REQ-038 Second DATA write during busy -> OVR=1, first transfer bytes unaffected.
REQ-039 Clear EN at half-period 5 -> sclk=0, BUSY=0, DONE=0 next cycle.
REQ-040 Assert HRESETn low at half-period 9 -> all outputs at reset values; no DONE after release.
